// File: rtl/mem_arbiter_pkg.sv
// Shared types for the L1-to-adaptor line-request arbiter.
package arb_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_I,
        ARB_PORT_D
    } arb_port_t;

    localparam int LINE_W = 256;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache line requests onto the single cacheline adaptor.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed dcache priority.
module mem_arbiter
    import arb_types::*;
#(
    parameter int LINE_W = arb_types::LINE_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read_c,
    output logic              pmem_write_c,
    output logic [ADDR_W-1:0] pmem_address_c,
    output logic [LINE_W-1:0] pmem_wdata_c,
    input  logic [LINE_W-1:0] pmem_rdata_c,
    input  logic              pmem_resp_c
);

    arb_state_t        state_q, state_d;
    arb_port_t         last_grant_q, last_grant_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              i_pend, d_pend, grant_d_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_PORT_I;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        i_pend = i_pmem_read;
        d_pend = d_pmem_read | d_pmem_write;
`ifdef ARB_ROUND_ROBIN_EN
        // Tie goes to whichever port was not served last.
        grant_d_port = d_pend & (~i_pend | (last_grant_q == ARB_PORT_I));
`else
        grant_d_port = d_pend;
`endif

        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant_d_port) begin
                    state_d      = ARB_SERVE_D;
                    last_grant_d = ARB_PORT_D;
                    op_write_d   = d_pmem_write;
                    addr_d       = d_pmem_address;
                    // Reads carry no payload, so the adaptor sees a zero line.
                    wdata_d      = d_pmem_write ? d_pmem_wdata : '0;
                end else if (i_pend) begin
                    state_d      = ARB_SERVE_I;
                    last_grant_d = ARB_PORT_I;
                    op_write_d   = 1'b0;
                    addr_d       = i_pmem_address;
                    wdata_d      = '0;
                end
            end
            ARB_SERVE_I: begin
                if (pmem_resp_c) begin
                    i_pmem_resp = 1'b1;
                    state_d     = ARB_IDLE;
                end
            end
            ARB_SERVE_D: begin
                if (pmem_resp_c) begin
                    d_pmem_resp = 1'b1;
                    state_d     = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign pmem_read_c    = (state_q != ARB_IDLE) & ~op_write_q;
    assign pmem_write_c   = (state_q != ARB_IDLE) &  op_write_q;
    assign pmem_address_c = addr_q;
    assign pmem_wdata_c   = wdata_q;
    assign i_pmem_rdata   = pmem_rdata_c;
    assign d_pmem_rdata   = pmem_rdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level model and scripted cache/adaptor agents.
module tb_mem_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read, d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata, d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read_c, pmem_write_c;
    logic [AW-1:0] pmem_address_c;
    logic [LW-1:0] pmem_wdata_c, pmem_rdata_c;
    logic          pmem_resp_c;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read_c(pmem_read_c), .pmem_write_c(pmem_write_c),
        .pmem_address_c(pmem_address_c), .pmem_wdata_c(pmem_wdata_c),
        .pmem_rdata_c(pmem_rdata_c), .pmem_resp_c(pmem_resp_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } dreq_t;

    dreq_t         dq[$];
    logic [AW-1:0] iq[$];
    int            glog[$];      // model grant order: 0 = icache, 1 = dcache
    int            req_rise[$];  // cycles where the adaptor request rose

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 3;
    int a_cnt = 0;
    logic spur = 1'b0;
    logic noise = 1'b0;
    logic i_seen = 1'b0, d_seen = 1'b0, prev_req = 1'b0;

    logic          m_busy, m_port, m_wr, m_last;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;

    int            n_rd, n_wr, n_ir, n_dr, rd_first, ir_cyc, dr_cyc, i_rise;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [LW-1:0] wb_last;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_port = 1'b0; m_wr = 1'b0; m_last = 1'b0;
        m_addr = '0;   m_wdata = '0;
    endtask

    task automatic clr_cnt();
        n_rd = 0; n_wr = 0; n_ir = 0; n_dr = 0;
        rd_first = -1; ir_cyc = -1; dr_cyc = -1; i_rise = -1;
        rd_addr = '0; wr_addr = '0; wb_last = '0;
        req_rise.delete();
    endtask

    // Agents: adaptor answers after lat request cycles; caches hold a request until its resp.
    task automatic drive();
        logic was_i;
        if (rst) begin
            a_cnt = 0; pmem_resp_c = 1'b0;
        end else if (pmem_read_c || pmem_write_c) begin
            a_cnt++;
            pmem_resp_c = (a_cnt == lat);
        end else begin
            a_cnt = 0;
            pmem_resp_c = spur;
        end
        spur = 1'b0;
        pmem_rdata_c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (i_seen && iq.size() > 0) void'(iq.pop_front());
        if (d_seen && dq.size() > 0) void'(dq.pop_front());
        i_seen = 1'b0; d_seen = 1'b0;
        was_i = i_pmem_read;
        i_pmem_read    = (iq.size() > 0);
        i_pmem_address = (iq.size() > 0) ? iq[0] : '0;
        if (i_pmem_read && !was_i) i_rise = cyc;
        if (dq.size() > 0) begin
            d_pmem_read    = dq[0].rd;
            d_pmem_write   = dq[0].wr;
            d_pmem_address = dq[0].addr;
            d_pmem_wdata   = (noise && pmem_write_c) ?
                {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} : dq[0].wdata;
        end else begin
            d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        end
    endtask

    task automatic step();
        logic ip, dp, gd;
        @(negedge clk);
        if (!rst) begin
            chk("read_c",  pmem_read_c,  m_busy && !m_wr);
            chk("write_c", pmem_write_c, m_busy &&  m_wr);
            chk("addr_c",  pmem_address_c, m_addr);
            chk("wdata_c", pmem_wdata_c, m_wdata);
            chk("i_resp",  i_pmem_resp, m_busy && !m_port && pmem_resp_c);
            chk("d_resp",  d_pmem_resp, m_busy &&  m_port && pmem_resp_c);
            chk("i_rdata", i_pmem_rdata, pmem_rdata_c);
            chk("d_rdata", d_pmem_rdata, pmem_rdata_c);

            if (pmem_read_c) begin
                n_rd++; rd_addr = pmem_address_c;
                if (rd_first < 0) rd_first = cyc;
            end
            if (pmem_write_c) begin
                n_wr++; wr_addr = pmem_address_c; wb_last = pmem_wdata_c;
            end
            if ((pmem_read_c || pmem_write_c) && !prev_req) req_rise.push_back(cyc);
            prev_req = pmem_read_c || pmem_write_c;
            if (i_pmem_resp) begin n_ir++; ir_cyc = cyc; end
            if (d_pmem_resp) begin n_dr++; dr_cyc = cyc; end

            if (m_busy) begin
                if (pmem_resp_c) m_busy = 1'b0;
            end else begin
                ip = i_pmem_read;
                dp = d_pmem_read | d_pmem_write;
`ifdef ARB_ROUND_ROBIN_EN
                gd = dp && (!ip || !m_last);
`else
                gd = dp;
`endif
                if (ip || dp) begin
                    m_busy = 1'b1; m_port = gd; m_last = gd;
                    glog.push_back(gd ? 1 : 0);
                    if (gd) begin
                        m_wr = d_pmem_write; m_addr = d_pmem_address;
                        m_wdata = d_pmem_write ? d_pmem_wdata : '0;
                    end else begin
                        m_wr = 1'b0; m_addr = i_pmem_address; m_wdata = '0;
                    end
                end
            end
        end
        i_seen = i_pmem_resp;
        d_seen = d_pmem_resp;
        @(posedge clk); #1;
        cyc++;
        drive();
    endtask

    task automatic run(input string name, input int bound);
        int n = 0;
        do begin
            step(); n++;
        end while ((iq.size() > 0 || dq.size() > 0 || m_busy) && n < bound);
        chk({"timeout_", name}, (n < bound), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dq.delete(); iq.delete();
        model_reset();
        prev_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    dreq_t r;
    int    exp_g[13];

    initial begin
        rst = 1'b1;
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata_c = '0; pmem_resp_c = 0;
        model_reset();
        clr_cnt();
        @(posedge clk); #1;
        chk("rst_read_c",  pmem_read_c, 1'b0);
        chk("rst_write_c", pmem_write_c, 1'b0);
        chk("rst_addr_c",  pmem_address_c, '0);
        chk("rst_wdata_c", pmem_wdata_c, '0);
        chk("rst_i_resp",  i_pmem_resp, 1'b0);
        chk("rst_d_resp",  d_pmem_resp, 1'b0);
        rst = 1'b0;
        drive();

        // Icache read alone, resp on 5th serve cycle
        lat = 5; clr_cnt(); glog.delete();
        iq.push_back(32'h0000_0060);
        run("t1", 40);
        chk("t1_rd_cycles", n_rd, 5);
        chk("t1_wr_cycles", n_wr, 0);
        chk("t1_i_resp_cnt", n_ir, 1);
        chk("t1_d_resp_cnt", n_dr, 0);
        chk("t1_grant_lat", rd_first - i_rise, 1);
        chk("t1_resp_cycle", ir_cyc - i_rise, 5);
        chk("t1_addr", rd_addr, 32'h60);
        chk("t1_grant", glog[0], 0);

        // Dcache writeback with wdata toggling mid-transfer
        lat = 4; clr_cnt(); noise = 1'b1;
        r = '{1'b0, 1'b1, 32'h0000_1000, {8{32'hDEADBEEF}}};
        dq.push_back(r);
        run("t2", 40);
        noise = 1'b0;
        chk("t2_wr_cycles", n_wr, 4);
        chk("t2_rd_cycles", n_rd, 0);
        chk("t2_d_resp_cnt", n_dr, 1);
        chk("t2_i_resp_cnt", n_ir, 0);
        chk("t2_addr", wr_addr, 32'h1000);
        chk("t2_wdata", wb_last, {8{32'hDEADBEEF}});

        // Read and write both asserted: write wins
        lat = 2; clr_cnt();
        r = '{1'b1, 1'b1, 32'h0000_2000, {8{32'h12345678}}};
        dq.push_back(r);
        run("t2b", 40);
        chk("t2b_wr_cycles", n_wr, 2);
        chk("t2b_rd_cycles", n_rd, 0);
        chk("t2b_wdata", wb_last, {8{32'h12345678}});

        // Simultaneous reads after reset: D, IDLE gap, I, then third tie to D
        do_reset(); clr_cnt(); glog.delete(); lat = 2;
        r = '{1'b1, 1'b0, 32'h0000_3000, '0};
        dq.push_back(r);
        iq.push_back(32'h0000_4000);
        run("t3", 40);
        chk("t3_grants", glog.size(), 2);
        chk("t3_first_d", glog[0], 1);
        chk("t3_second_i", glog[1], 0);
        chk("t3_turnaround", req_rise[1] - dr_cyc, 2);
        r = '{1'b1, 1'b0, 32'h0000_5000, '0};
        dq.push_back(r);
        iq.push_back(32'h0000_6000);
        run("t3b", 40);
        chk("t3_third_d", glog[2], 1);

        // Continuous dcache traffic with icache requests held
        do_reset(); clr_cnt(); glog.delete(); lat = 2;
        for (int k = 0; k < 10; k++) begin
            r = '{1'b1, 1'b0, 32'h0001_0000 + 32'(k * 32'h40), '0};
            dq.push_back(r);
        end
        for (int k = 0; k < 3; k++) iq.push_back(32'h0002_0000 + 32'(k * 32'h40));
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
`else
        exp_g = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
`endif
        run("t4", 300);
        chk("t4_grants", glog.size(), 13);
        for (int k = 0; k < 13; k++)
            if (k < glog.size()) chk($sformatf("t4_grant%0d", k), glog[k], exp_g[k]);

        // Reset during dcache service aborts it; held icache request then served
        do_reset(); clr_cnt(); glog.delete(); lat = 8;
        r = '{1'b0, 1'b1, 32'h0000_7000, {8{32'hCAFEF00D}}};
        dq.push_back(r);
        iq.push_back(32'h0000_8000);
        for (int k = 0; k < 10; k++) begin
            step();
            if (pmem_write_c) break;
        end
        chk("t5_in_serve_d", pmem_write_c, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_read_c",  pmem_read_c, 1'b0);
        chk("t5_rst_write_c", pmem_write_c, 1'b0);
        chk("t5_rst_addr_c",  pmem_address_c, '0);
        chk("t5_rst_wdata_c", pmem_wdata_c, '0);
        chk("t5_rst_d_resp",  d_pmem_resp, 1'b0);
        dq.delete();
        model_reset();
        prev_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        run("t5", 40);
        chk("t5_d_resp_cnt", n_dr, 0);
        chk("t5_i_resp_cnt", n_ir, 1);
        chk("t5_grants", glog.size(), 2);
        if (glog.size() > 1) chk("t5_then_i", glog[1], 0);

        // Spurious adaptor resp while idle
        clr_cnt(); lat = 1;
        spur = 1'b1;
        step(); step(); step();
        chk("t6_no_i_resp", n_ir, 0);
        chk("t6_no_d_resp", n_dr, 0);
        chk("t6_no_req", n_rd + n_wr, 0);
        iq.push_back(32'h0000_9000);
        run("t6", 20);
        chk("t6_i_resp_cnt", n_ir, 1);
        chk("t6_grant_lat", rd_first - i_rise, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
